clk_div_gen: RTL and testbench

- Programmable clock-enable/divider stage fed directly by the free-running bench/system clock `clk`.
- Produces a registered divided clock `clk_out`, a one-cycle `tick` at the end of each divided period, and a completed-period counter.
- Supports runtime divisor changes. A new divisor only takes effect at a period boundary, so `clk_out` never glitches.
- Sits between the clock source and any slow-rate consumer (sample strobes, LED blink, UART bit timing).

---
 rtl/clk_div_gen.sv | 129 ++++++++++++
 tb/tb_clk_div_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// Programmable clock divider: registered divided clock, end-of-period tick and
// completed-period counter. Divisor changes take effect only at period boundaries.
module clk_div_gen #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div_in,
   input  logic             div_load,
   output logic             div_ack,
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
   output logic [15:0]      cycle_cnt,
   output logic [1:0]       dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_STOP = 2'd2;

   localparam logic [DIV_W-1:0] ONE_N   = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO_N   = DIV_W'(2);
   localparam logic [DIV_W:0]   ONE_H   = (DIV_W+1)'(1);
   localparam logic [DIV_W-1:0] DEF_N   = DIV_W'(DEFAULT_DIV);

   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] n_q, n_d;
   logic [DIV_W-1:0] pend_div_q, pend_div_d;
   logic             pend_q, pend_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             ack_q, ack_d;
   logic [15:0]      cycle_cnt_q, cycle_cnt_d;
   logic [DIV_W-1:0] load_val;
   logic [DIV_W:0]   high_d;
   logic             wrap;
   logic             run_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      n_d        = n_q;
      pend_d     = pend_q;
      pend_div_d = pend_div_q;
      ack_d      = 1'b0;

      load_val = (div_in < TWO_N) ? TWO_N : div_in;
      wrap     = (state_q != S_IDLE) && (cnt_q == n_q - ONE_N);

      // A strobe in a boundary cycle wins over an older pending value.
      if ((state_q == S_IDLE) || wrap) begin
         if (div_load) begin
            n_d    = load_val;
            ack_d  = 1'b1;
            pend_d = 1'b0;
         end else if (pend_q) begin
            n_d    = pend_div_q;
            ack_d  = 1'b1;
            pend_d = 1'b0;
         end
      end else if (div_load) begin
         pend_d     = 1'b1;
         pend_div_d = load_val;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (en) state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = wrap ? '0 : cnt_q + ONE_N;
            if (!en) state_d = wrap ? S_IDLE : S_STOP;
         end
         S_STOP: begin
            cnt_d = wrap ? '0 : cnt_q + ONE_N;
            if (en)        state_d = S_RUN;
            else if (wrap) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Waveform flops are derived from the next count and next divisor.
      run_d       = (state_d != S_IDLE);
      high_d      = ({1'b0, n_d} + ONE_H) >> 1;
      clk_out_d   = run_d && ({1'b0, cnt_d} < high_d);
      tick_d      = run_d && (cnt_d == n_d - ONE_N);
      cycle_cnt_d = cycle_cnt_q + {15'd0, tick_q};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         n_q         <= DEF_N;
         pend_q      <= 1'b0;
         pend_div_q  <= '0;
         clk_out_q   <= 1'b0;
         tick_q      <= 1'b0;
         ack_q       <= 1'b0;
         cycle_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         pend_q      <= pend_d;
         pend_div_q  <= pend_div_d;
         clk_out_q   <= clk_out_d;
         tick_q      <= tick_d;
         ack_q       <= ack_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign clk_out   = clk_out_q;
   assign tick      = tick_q;
   assign div_ack   = ack_q;
   assign busy      = (state_q != S_IDLE);
   assign cycle_cnt = cycle_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: directed scenarios plus random traffic, checked against
// a period-queue model (each started period enqueues its N expected cycles).
module tb_clk_div_gen;

   localparam int DIV_W = 8;
   localparam int DEF   = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        div_load = 1'b0;
   logic [7:0]  div_in = 8'd0;
   logic        div_ack, clk_out, tick, busy;
   logic [15:0] cycle_cnt;
   logic [1:0]  dbg_state;
   logic [19:0] dut_vec;

   int checks = 0;
   int errors = 0;

   // Model: one entry {clk_out, tick} per remaining cycle of the current period.
   logic [1:0]  exp_q[$];
   int          m_n = DEF;
   bit          m_pend = 1'b0;
   int          m_pend_val = 0;
   bit          m_ack = 1'b0;
   logic [15:0] m_cyc = 16'd0;

   clk_div_gen #(.DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .div_in(div_in), .div_load(div_load),
      .div_ack(div_ack), .clk_out(clk_out), .tick(tick), .busy(busy),
      .cycle_cnt(cycle_cnt), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   assign dut_vec = {clk_out, tick, busy, div_ack, cycle_cnt};

   function automatic int clamp(input int d);
      return (d < 2) ? 2 : d;
   endfunction

   function automatic logic [19:0] exp_vec();
      if (exp_q.size() > 0) return {exp_q[0][1], exp_q[0][0], 1'b1, m_ack, m_cyc};
      return {1'b0, 1'b0, 1'b0, m_ack, m_cyc};
   endfunction

   function automatic int model_cnt();
      return m_n - exp_q.size();
   endfunction

   task automatic model_edge();
      int lv;
      bit boundary;
      bit cur_tick;
      if (!rst_n) begin
         exp_q.delete();
         m_n = DEF; m_pend = 1'b0; m_ack = 1'b0; m_cyc = 16'd0;
         return;
      end
      cur_tick = (exp_q.size() > 0) ? exp_q[0][0] : 1'b0;
      m_cyc    = m_cyc + 16'(cur_tick);
      boundary = (exp_q.size() <= 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_ack = 1'b0;
      lv    = clamp(int'(div_in));
      if (boundary) begin
         if (div_load) begin
            m_n = lv; m_ack = 1'b1; m_pend = 1'b0;
         end else if (m_pend) begin
            m_n = m_pend_val; m_ack = 1'b1; m_pend = 1'b0;
         end
         if (en)
            for (int k = 0; k < m_n; k++)
               exp_q.push_back({(k < (m_n + 1) / 2) ? 1'b1 : 1'b0, (k == m_n - 1) ? 1'b1 : 1'b0});
      end else if (div_load) begin
         m_pend = 1'b1; m_pend_val = lv;
      end
   endtask

   task automatic step(input bit e, input bit ld, input int d);
      en = e; div_load = ld; div_in = 8'(d);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic go_idle();
      int n = 0;
      while (exp_q.size() > 0 && n < 300) begin
         step(1'b0, 1'b0, 0);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL go_idle: busy=%b after %0d cycles, required 0", busy, n);
      end
   endtask

   task automatic wait_cnt(input int k);
      int n = 0;
      while (!(exp_q.size() > 0 && model_cnt() == k) && n < 300) begin
         step(1'b1, 1'b0, 0);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL wait_cnt: count %0d not reached within 300 cycles", k);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(1'b1, 1'b1, 9);
      step(1'b0, 1'b0, 0);
      rst_n = 1'b1;
      checks++;
      if (dut_vec !== 20'd0) begin
         errors++;
         $display("FAIL reset: outputs %h, required 0", dut_vec);
      end
   endtask

   task automatic test_default_div();
      for (int i = 1; i <= 13; i++) begin
         step(1'b1, 1'b0, 0);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL default_div model cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         checks++;
         if ({clk_out, tick} !== {(((i - 1) % 4) < 2) ? 1'b1 : 1'b0, (((i - 1) % 4) == 3) ? 1'b1 : 1'b0}) begin
            errors++;
            $display("FAIL default_div pattern cyc %0d: clk_out=%b tick=%b", i, clk_out, tick);
         end
      end
      checks++;
      if (cycle_cnt !== 16'd3) begin
         errors++;
         $display("FAIL default_div cycle_cnt: got %0d required 3", cycle_cnt);
      end
   endtask

   task automatic test_idle_load();
      go_idle();
      step(1'b0, 1'b1, 5);
      checks++;
      if ({div_ack, busy} !== 2'b10 || dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL idle_load ack: div_ack=%b busy=%b, required 1 0", div_ack, busy);
      end
      for (int i = 1; i <= 10; i++) begin
         step(1'b1, 1'b0, 0);
         checks++;
         if (dut_vec !== exp_vec() ||
             {clk_out, tick} !== {(((i - 1) % 5) < 3) ? 1'b1 : 1'b0, (((i - 1) % 5) == 4) ? 1'b1 : 1'b0}) begin
            errors++;
            $display("FAIL idle_load N5 cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_midperiod_load();
      go_idle();
      step(1'b0, 1'b1, 4);
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 6);
      step(1'b1, 1'b0, 0);
      checks++;
      if ({clk_out, div_ack} !== 2'b00 || dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL midperiod old period: got %h expected %h", dut_vec, exp_vec());
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 0);
         checks++;
         if (dut_vec !== exp_vec() ||
             {clk_out, div_ack} !== {(i < 3) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0}) begin
            errors++;
            $display("FAIL midperiod N6 cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_double_load();
      int acks = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, (i == 1) || (i == 3), (i == 1) ? 7 : 3);
         acks += int'(div_ack);
         checks++;
         if (dut_vec !== exp_vec() || div_ack !== ((i == 6) ? 1'b1 : 1'b0) ||
             (i >= 6 && clk_out !== ((((i - 6) % 3) < 2) ? 1'b1 : 1'b0))) begin
            errors++;
            $display("FAIL double_load cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
      checks++;
      if (acks != 1) begin
         errors++;
         $display("FAIL double_load ack count: got %0d required 1", acks);
      end
   endtask

   task automatic test_clamp();
      go_idle();
      step(1'b0, 1'b1, 0);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, i == 8, 1);
         checks++;
         if (dut_vec !== exp_vec() ||
             {clk_out, tick} !== {((i % 2) == 0) ? 1'b1 : 1'b0, ((i % 2) == 1) ? 1'b1 : 1'b0}) begin
            errors++;
            $display("FAIL clamp cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_stop();
      go_idle();
      step(1'b0, 1'b1, 8);
      for (int i = 1; i <= 10; i++) begin
         step(i < 3, 1'b0, 0);
         checks++;
         if (dut_vec !== exp_vec() || busy !== ((i <= 8) ? 1'b1 : 1'b0) ||
             (i >= 9 && clk_out !== 1'b0)) begin
            errors++;
            $display("FAIL stop drain cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
      for (int i = 1; i <= 20; i++) begin
         step(!(i >= 3 && i <= 6), 1'b0, 0);
         checks++;
         if (dut_vec !== exp_vec() || busy !== 1'b1) begin
            errors++;
            $display("FAIL stop resume cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
      wait_cnt(2);
      step(1'b1, 1'b1, 5);
      rst_n = 1'b0;
      step(1'b1, 1'b0, 0);
      rst_n = 1'b1;
      checks++;
      if (dut_vec !== 20'd0) begin
         errors++;
         $display("FAIL stop reset: outputs %h, required 0", dut_vec);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 0);
         checks++;
         if (dut_vec !== exp_vec() || div_ack !== 1'b0 ||
             clk_out !== (((i % 4) < 2) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL stop post-reset cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      bit e, ld;
      int d;
      for (int i = 0; i < 1500; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         e  = ($urandom_range(0, 9) < 7);
         ld = ($urandom_range(0, 7) == 0);
         d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
         step(e, ld, d);
         rst_n = 1'b1;
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_default_div();
      test_idle_load();
      test_midperiod_load();
      test_double_load();
      test_clamp();
      test_stop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
